// File: rtl/burger_pkg.sv
// Shared types and screen geometry for the burger stage: ingredient states,
// sweep sequencer states and the bound-RAM addressing constants.
package burger_pkg;

   typedef enum logic [1:0] {
      ING_REST  = 2'd0,
      ING_FALL  = 2'd1,
      ING_PLATE = 2'd2
   } ing_state_t;

   typedef enum logic [2:0] {
      SW_IDLE   = 3'd0,
      SW_WALK   = 3'd1,
      SW_ISSUE  = 3'd2,
      SW_WAIT   = 3'd3,
      SW_UPDATE = 3'd4
   } sweep_state_t;

   localparam int SCREEN_W  = 640;
   localparam int ING_W     = 32;
   localparam int ING_H     = 8;
   localparam int SEG_COUNT = 4;
   localparam int CHEF_SZ   = 16;
   localparam int BOUND_AW  = 19;

   // Probe point below the ingredient's horizontal centre.
   localparam int PROBE_DY  = 6;
   localparam int PROBE_DX  = ING_W / 2;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/bound_addr_gen.sv
// Stage-bound RAM address for the pixel under a sprite: (y+6)*640 + x+16,
// wrapped to the RAM address width. Shared with the chef ladder lookups.
module bound_addr_gen
   import burger_pkg::*;
(
   input  logic [9:0]          x,
   input  logic [9:0]          y,
   output logic [BOUND_AW-1:0] addr
);

   logic [BOUND_AW-1:0] row_base;

   always_comb begin
      row_base = (BOUND_AW'(y) + BOUND_AW'(PROBE_DY)) * BOUND_AW'(SCREEN_W);
      addr     = row_base + BOUND_AW'(x) + BOUND_AW'(PROBE_DX);
   end

endmodule

// File: rtl/ingredient_bank.sv
// Bank of N_ING burger ingredients. Each frame tick starts a fixed-length sweep
// that walks, probes the bound RAM, then falls/stacks/plates one ingredient at a time.
module ingredient_bank
   import burger_pkg::*;
#(
   parameter int                  N_ING     = 4,
   parameter logic [10*N_ING-1:0] START_X   = {N_ING{10'd32}},
   parameter logic [10*N_ING-1:0] START_Y   = {10'd236, 10'd188, 10'd140, 10'd92},
   parameter logic [9:0]          END_Y     = 10'd360,
   parameter int                  FALL_STEP = 2,
   parameter int                  MIN_DROP  = 8,
   parameter int                  RD_LAT    = 1
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  frame_tick,
   input  logic [9:0]            chef_x,
   input  logic [9:0]            chef_y,
   output logic [BOUND_AW-1:0]   bound_addr,
   input  logic                  bound_q,
   output logic [10*N_ING-1:0]   ing_x,
   output logic [10*N_ING-1:0]   ing_y,
   output logic [N_ING-1:0]      falling,
   output logic [N_ING-1:0]      plated,
   output logic                  score_evt,
   output logic                  busy,
   output logic                  overrun
);

   localparam int IW = (N_ING > 1) ? $clog2(N_ING) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_ING - 1);

   sweep_state_t        fsm_reg;
   logic [IW-1:0]       idx_reg;
   logic [1:0]          wait_cnt_reg;
   logic                busy_reg;
   logic                overrun_reg;
   logic                score_reg, score_next;
   logic [BOUND_AW-1:0] bound_addr_reg, probe_addr;

   logic [9:0]          x_arr    [N_ING];
   logic [9:0]          y_reg    [N_ING];
   logic [9:0]          y_next   [N_ING];
   ing_state_t          st_reg   [N_ING];
   ing_state_t          st_next  [N_ING];
   logic [3:0]          seg_reg  [N_ING];
   logic [3:0]          seg_next [N_ING];
   logic [7:0]          dist_reg [N_ING];
   logic [7:0]          dist_next[N_ING];
   // Ingredients that became FALL during this sweep; they first move next sweep.
   logic [N_ING-1:0]    hold_reg, hold_next;
   logic [N_ING-1:0]    falling_reg, plated_reg;

   logic [9:0]          cur_x, cur_y;
   logic [10:0]         chef_cx, chef_foot, next_y;
   logic                walk_hit;
   logic [1:0]          walk_seg;
   logic [3:0]          walk_mask;
   logic                stack_hit;
   logic [9:0]          stack_y;
   logic [IW-1:0]       stack_j;

   genvar gi;
   generate
      for (gi = 0; gi < N_ING; gi++) begin : g_ing
         assign x_arr[gi]              = START_X[10*gi +: 10];
         assign ing_x[10*gi +: 10]     = x_arr[gi];
         assign ing_y[10*gi +: 10]     = y_reg[gi];
      end
   endgenerate

   assign cur_x = x_arr[idx_reg];
   assign cur_y = y_reg[idx_reg];

   bound_addr_gen u_addr (
      .x    (cur_x),
      .y    (cur_y),
      .addr (probe_addr)
   );

   // Chef foot-centre against the current ingredient's top edge.
   always_comb begin
      chef_cx   = {1'b0, chef_x} + 11'(CHEF_SZ / 2);
      chef_foot = {1'b0, chef_y} + 11'(CHEF_SZ);
      walk_hit  = (chef_foot == {1'b0, cur_y}) &&
                  (chef_cx >= {1'b0, cur_x}) &&
                  (chef_cx <  {1'b0, cur_x} + 11'(ING_W));
      walk_seg  = 2'((chef_cx - {1'b0, cur_x}) >> 3);
      walk_mask = seg_reg[idx_reg] | (4'b0001 << walk_seg);
      next_y    = {1'b0, cur_y} + 11'(FALL_STEP);
   end

   // Nearest settled ingredient below the current one in the same column.
   always_comb begin
      stack_hit = 1'b0;
      stack_y   = '0;
      stack_j   = '0;
      for (int j = 0; j < N_ING; j++) begin
         if ((IW'(j) != idx_reg) && (x_arr[j] == cur_x) &&
             (st_reg[j] == ING_REST || st_reg[j] == ING_PLATE) &&
             (y_reg[j] > cur_y) && ({1'b0, y_reg[j]} <= next_y + 11'(ING_H)) &&
             (!stack_hit || y_reg[j] < stack_y)) begin
            stack_hit = 1'b1;
            stack_y   = y_reg[j];
            stack_j   = IW'(j);
         end
      end
   end

   always_comb begin
      y_next     = y_reg;
      st_next    = st_reg;
      seg_next   = seg_reg;
      dist_next  = dist_reg;
      hold_next  = hold_reg;
      score_next = 1'b0;
      case (fsm_reg)
         SW_IDLE: begin
            if (frame_tick) hold_next = '0;
         end
         SW_WALK: begin
            if (st_reg[idx_reg] == ING_REST && walk_hit) begin
               if (walk_mask == 4'hF) begin
                  st_next[idx_reg]   = ING_FALL;
                  seg_next[idx_reg]  = 4'h0;
                  dist_next[idx_reg] = 8'd0;
                  hold_next[idx_reg] = 1'b1;
               end else begin
                  seg_next[idx_reg]  = walk_mask;
               end
            end
         end
         SW_UPDATE: begin
            if (st_reg[idx_reg] == ING_FALL && !hold_reg[idx_reg]) begin
               if (next_y >= {1'b0, END_Y}) begin
                  y_next[idx_reg]  = END_Y;
                  st_next[idx_reg] = ING_PLATE;
                  score_next       = 1'b1;
               end else if (stack_hit) begin
                  y_next[idx_reg]    = stack_y - 10'(ING_H);
                  st_next[idx_reg]   = ING_REST;
                  dist_next[idx_reg] = 8'd0;
                  if (st_reg[stack_j] == ING_REST) begin
                     st_next[stack_j]   = ING_FALL;
                     dist_next[stack_j] = 8'd0;
                     hold_next[stack_j] = 1'b1;
                  end
               end else if (bound_q && dist_reg[idx_reg] >= 8'(MIN_DROP)) begin
                  st_next[idx_reg]   = ING_REST;
                  dist_next[idx_reg] = 8'd0;
               end else begin
                  y_next[idx_reg]    = next_y[9:0];
                  dist_next[idx_reg] = sat_add8(dist_reg[idx_reg], 8'(FALL_STEP));
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fsm_reg        <= SW_IDLE;
         idx_reg        <= '0;
         wait_cnt_reg   <= 2'd0;
         busy_reg       <= 1'b0;
         overrun_reg    <= 1'b0;
         score_reg      <= 1'b0;
         bound_addr_reg <= '0;
         hold_reg       <= '0;
         falling_reg    <= '0;
         plated_reg     <= '0;
         for (int k = 0; k < N_ING; k++) begin
            y_reg[k]    <= START_Y[10*k +: 10];
            st_reg[k]   <= ING_REST;
            seg_reg[k]  <= 4'h0;
            dist_reg[k] <= 8'd0;
         end
      end else begin
         for (int k = 0; k < N_ING; k++) begin
            y_reg[k]       <= y_next[k];
            st_reg[k]      <= st_next[k];
            seg_reg[k]     <= seg_next[k];
            dist_reg[k]    <= dist_next[k];
            falling_reg[k] <= (st_next[k] == ING_FALL);
            plated_reg[k]  <= (st_next[k] == ING_PLATE);
         end
         hold_reg    <= hold_next;
         score_reg   <= score_next;
         overrun_reg <= frame_tick && (fsm_reg != SW_IDLE);
         case (fsm_reg)
            SW_IDLE: begin
               if (frame_tick) begin
                  busy_reg <= 1'b1;
                  idx_reg  <= '0;
                  fsm_reg  <= SW_WALK;
               end
            end
            SW_WALK: begin
               fsm_reg <= SW_ISSUE;
            end
            SW_ISSUE: begin
               bound_addr_reg <= probe_addr;
               wait_cnt_reg   <= 2'd0;
               fsm_reg        <= SW_WAIT;
            end
            SW_WAIT: begin
               if (wait_cnt_reg == 2'(RD_LAT - 1)) fsm_reg <= SW_UPDATE;
               else wait_cnt_reg <= wait_cnt_reg + 2'd1;
            end
            SW_UPDATE: begin
               if (idx_reg == LAST_IDX) begin
                  busy_reg <= 1'b0;
                  fsm_reg  <= SW_IDLE;
               end else begin
                  idx_reg  <= idx_reg + 1'b1;
                  fsm_reg  <= SW_WALK;
               end
            end
            default: fsm_reg <= SW_IDLE;
         endcase
      end
   end

   assign bound_addr = bound_addr_reg;
   assign falling    = falling_reg;
   assign plated     = plated_reg;
   assign score_evt  = score_reg;
   assign busy       = busy_reg;
   assign overrun    = overrun_reg;

endmodule

// File: tb/tb_ingredient_bank.sv
// Bench for ingredient_bank: RD_LAT=1 and RD_LAT=2 instances driven in lockstep,
// compared per sweep against a frame-level model of the ingredient rules.
`timescale 1ns/1ps
module tb_ingredient_bank;

   localparam int N  = 4;
   localparam int SX = 32;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic [9:0]  chef_x = 10'd600;
   logic [9:0]  chef_y = 10'd600;
   logic [18:0] bound_addr, bound_addr2;
   logic        bound_q, bound_q2;
   logic [39:0] ing_x, ing_y, ing_x2, ing_y2;
   logic [3:0]  falling, plated, falling2, plated2;
   logic        score_evt, busy, overrun, score_evt2, busy2, overrun2;

   always #10 Clk = ~Clk;

   ingredient_bank dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
      .chef_x(chef_x), .chef_y(chef_y),
      .bound_addr(bound_addr), .bound_q(bound_q),
      .ing_x(ing_x), .ing_y(ing_y), .falling(falling), .plated(plated),
      .score_evt(score_evt), .busy(busy), .overrun(overrun)
   );

   ingredient_bank #(.RD_LAT(2)) dut2 (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
      .chef_x(chef_x), .chef_y(chef_y),
      .bound_addr(bound_addr2), .bound_q(bound_q2),
      .ing_x(ing_x2), .ing_y(ing_y2), .falling(falling2), .plated(plated2),
      .score_evt(score_evt2), .busy(busy2), .overrun(overrun2)
   );

   // Stage-bound RAM: 0 = empty, 1 = floor everywhere, 2 = address-hashed floor.
   int floor_mode = 0;
   function automatic logic floor_at(input int a);
      if (floor_mode == 2) return ((a ^ (a >> 4)) % 5) == 0;
      return floor_mode == 1;
   endfunction

   logic q1 = 1'b0, q2a = 1'b0, q2b = 1'b0;
   always @(posedge Clk) begin
      q1  <= floor_at(int'(bound_addr));
      q2a <= floor_at(int'(bound_addr2));
      q2b <= q2a;
   end
   assign bound_q  = q1;
   assign bound_q2 = q2b;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Frame-level model: state 0 rest, 1 fall, 2 plate. All ingredients share column SX.
   int start_y[N] = '{92, 140, 188, 236};
   int m_y[N], m_st[N], m_mask[N], m_dist[N];
   int m_plates, m_last_addr;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_y[i] = start_y[i]; m_st[i] = 0; m_mask[i] = 0; m_dist[i] = 0;
      end
   endtask

   task automatic model_sweep(input int cx, input int cy);
      bit held[N];
      int ny, best;
      m_plates = 0;
      for (int i = 0; i < N; i++) held[i] = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (m_st[i] == 0 && cy + 16 == m_y[i] && cx + 8 >= SX && cx + 8 < SX + 32) begin
            m_mask[i] = m_mask[i] | (1 << ((cx + 8 - SX) / 8));
            if (m_mask[i] == 15) begin
               m_st[i] = 1; m_mask[i] = 0; m_dist[i] = 0; held[i] = 1'b1;
            end
         end
         m_last_addr = ((m_y[i] + 6) * 640 + SX + 16) % 524288;
         if (m_st[i] == 1 && !held[i]) begin
            ny = m_y[i] + 2;
            best = -1;
            if (ny >= 360) begin
               m_y[i] = 360; m_st[i] = 2; m_plates++;
            end else begin
               for (int j = 0; j < N; j++)
                  if (j != i && m_st[j] != 1 && m_y[j] > m_y[i] && m_y[j] <= ny + 8 &&
                      (best < 0 || m_y[j] < m_y[best])) best = j;
               if (best >= 0) begin
                  m_y[i] = m_y[best] - 8; m_st[i] = 0; m_dist[i] = 0;
                  if (m_st[best] == 0) begin
                     m_st[best] = 1; m_dist[best] = 0; held[best] = 1'b1;
                  end
               end else if (floor_at(m_last_addr) && m_dist[i] >= 8) begin
                  m_st[i] = 0; m_dist[i] = 0;
               end else begin
                  m_y[i] = ny;
                  m_dist[i] = (m_dist[i] + 2 > 255) ? 255 : m_dist[i] + 2;
               end
            end
         end
      end
   endtask

   task automatic check_state(input string ph);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s y%0d", ph, i), 32'(ing_y[10*i +: 10]), m_y[i]);
         check($sformatf("%s y2_%0d", ph, i), 32'(ing_y2[10*i +: 10]), m_y[i]);
         check($sformatf("%s falling%0d", ph, i), 32'(falling[i]), 32'(m_st[i] == 1));
         check($sformatf("%s plated%0d", ph, i), 32'(plated[i]), 32'(m_st[i] == 2));
         check($sformatf("%s falling2_%0d", ph, i), 32'(falling2[i]), 32'(m_st[i] == 1));
         check($sformatf("%s plated2_%0d", ph, i), 32'(plated2[i]), 32'(m_st[i] == 2));
      end
   endtask

   task automatic run_sweep(input string ph, input bit extra);
      int b1, b2, sc, sc2, ov, ov2;
      bit done;
      b1 = 0; b2 = 0; sc = 0; sc2 = 0; ov = 0; ov2 = 0; done = 1'b0;
      model_sweep(int'(chef_x), int'(chef_y));
      @(negedge Clk);
      frame_tick = 1'b1;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge Clk);
         frame_tick = extra && (c == 1);
         b1 += int'(busy);       b2 += int'(busy2);
         sc += int'(score_evt);  sc2 += int'(score_evt2);
         ov += int'(overrun);    ov2 += int'(overrun2);
         if (c > 0 && !busy && !busy2) done = 1'b1;
      end
      check({ph, " sweep_done"}, 32'(done), 1);
      check({ph, " busy_len"}, b1, 4 * N);
      check({ph, " busy_len_rdlat2"}, b2, 5 * N);
      check({ph, " score"}, sc, m_plates);
      check({ph, " score2"}, sc2, m_plates);
      check({ph, " overrun"}, ov, 32'(extra));
      check({ph, " overrun2"}, ov2, 32'(extra));
      check({ph, " last_addr"}, 32'(bound_addr), m_last_addr);
      check_state(ph);
      $display("[TB] %s: y={%0d,%0d,%0d,%0d} falling=%b plated=%b", ph,
               m_y[0], m_y[1], m_y[2], m_y[3], falling, plated);
   endtask

   task automatic pulse_reset();
      @(negedge Clk); Reset_n = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int idle_busy, k;
      model_reset();

      // Reset state
      repeat (3) @(negedge Clk);
      for (int i = 0; i < N; i++) begin
         check($sformatf("rst x%0d", i), 32'(ing_x[10*i +: 10]), SX);
         check($sformatf("rst x2_%0d", i), 32'(ing_x2[10*i +: 10]), SX);
      end
      check_state("rst");
      check("rst busy", 32'(busy), 0);
      check("rst bound_addr", 32'(bound_addr), 0);
      check("rst score", 32'(score_evt), 0);
      check("rst overrun", 32'(overrun), 0);
      Reset_n = 1'b1;

      // Walk ingredient 0 segment by segment, then fall onto a solid floor
      floor_mode = 1;
      chef_y = 10'd76;
      for (int s = 0; s < 4; s++) begin
         chef_x = 10'(24 + 8 * s);
         run_sweep($sformatf("walk%0d", s), 1'b0);
      end
      chef_x = 10'd600; chef_y = 10'd600;
      for (int s = 0; s < 6; s++) run_sweep($sformatf("floor%0d", s), 1'b0);

      // Knock it off again, then reset in the middle of a sweep
      chef_y = 10'd84;
      for (int s = 0; s < 4; s++) begin
         chef_x = 10'(24 + 8 * s);
         run_sweep($sformatf("rewalk%0d", s), 1'b0);
      end
      chef_x = 10'd600; chef_y = 10'd600;
      run_sweep("refall", 1'b0);
      @(negedge Clk); frame_tick = 1'b1;
      @(negedge Clk); frame_tick = 1'b0;
      repeat (6) @(negedge Clk);
      check("mid busy_before_reset", 32'(busy), 1);
      Reset_n = 1'b0;
      model_reset();
      @(negedge Clk);
      check_state("midrst");
      check("midrst busy", 32'(busy), 0);
      check("midrst busy2", 32'(busy2), 0);
      check("midrst bound_addr", 32'(bound_addr), 0);
      Reset_n = 1'b1;

      // Empty stage: stack, cascade down the column, plate the bottom one
      floor_mode = 0;
      chef_y = 10'd76;
      for (int s = 0; s < 4; s++) begin
         chef_x = 10'(24 + 8 * s);
         run_sweep($sformatf("cwalk%0d", s), 1'b0);
      end
      chef_x = 10'd600; chef_y = 10'd600;
      for (int s = 0; s < 200 && m_st[3] != 2; s++) begin
         run_sweep($sformatf("cascade%0d", s), s == 10);
         if (s == 10) begin
            idle_busy = 0;
            repeat (10) begin
               @(negedge Clk);
               idle_busy += int'(busy) + int'(busy2);
            end
            check("dropped_tick no_extra_sweep", idle_busy, 0);
         end
      end
      check("cascade plated3", 32'(m_st[3]), 2);
      for (int s = 0; s < 3; s++) run_sweep($sformatf("post_plate%0d", s), 1'b0);

      // Randomised chef walks over a hashed floor
      pulse_reset();
      floor_mode = 2;
      for (int s = 0; s < 80; s++) begin
         k = $urandom_range(0, N - 1);
         chef_x = 10'($urandom_range(16, 60));
         if ($urandom_range(0, 3) == 0) chef_y = 10'($urandom_range(0, 400));
         else chef_y = 10'(m_y[k] - 16);
         run_sweep($sformatf("rand%0d", s), $urandom_range(0, 7) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ingredient_bank.md
Name: ingredient_bank

Overview:
- Parametrised successor to the single-ingredient controller. Owns N burger ingredients and tracks, per ingredient, position, walked-over segments and fall state.
- Runs on the system clock. Per frame, it processes each ingredient in turn through one shared read port of the stage-bound RAM (floor = 1).
- Adds behaviour the single-ingredient block lacks:
  - per-segment walk tracking;
  - minimum-drop floor skipping;
  - ingredient-on-ingredient stacking with cascade knock-down;
  - plate detection with score event;
  - frame-overrun reporting.
- Sits between the chef module / frame-tick source and the sprite-offset and colour-mapper logic.

Parameters:
- N_ING, 4, number of ingredients (1..8).
- START_X, {4{10'd32}}, packed N_ING×10 start X, ingredient i in bits [10i+9:10i].
- START_Y, {10'd236,10'd188,10'd140,10'd92}, packed N_ING×10 start Y.
- END_Y, 10'd360, plate row; Y is never exceeded.
- FALL_STEP, 2, pixels added per frame while falling.
- MIN_DROP, 8, pixels of fall before a floor hit may stop the ingredient.
- RD_LAT, 1, bound-RAM read latency in cycles (1 or 2).

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-Clk pulse per frame, synchronous to Clk.
- chef_x  in  10  chef sprite top-left X.
- chef_y  in  10  chef sprite top-left Y.
- bound_addr  out  19  stage-bound RAM address.
- bound_q  in  1  stage-bound RAM data (1 = floor).
- ing_x  out  10·N_ING  packed ingredient X.
- ing_y  out  10·N_ING  packed ingredient Y.
- falling  out  N_ING  ingredient i is in FALL.
- plated  out  N_ING  ingredient i is in PLATE.
- score_evt  out  1  one-cycle pulse when any ingredient enters PLATE.
- busy  out  1  frame sweep in progress.
- overrun  out  1  one-cycle pulse when frame_tick arrives while busy.

Behaviour:
- **Reset (async, Reset_n=0):**
  - ing_x/ing_y = START_X/START_Y;
  - all ingredients REST, seg masks 0, fall_dist 0;
  - FSM IDLE;
  - bound_addr = 0, busy = 0, score_evt = 0, overrun = 0.
  - Reset asserted mid-sweep aborts the sweep; no partial update survives.
- **Per-ingredient state (ing_state_t):** REST, FALL, PLATE. PLATE is terminal until reset.
- **Sweep FSM:** IDLE → WALK → ISSUE → WAIT → UPDATE → (next i, or IDLE after i = N_ING−1).
  - IDLE: frame_tick → busy = 1, i = 0, go to WALK.
  - WALK, REST only: if chef_y+16 == ing_y and chef_x+8 in [ing_x, ing_x+32), set seg bit (chef_x+8−ing_x)>>3 (4 segments of 8 px).
    - Mask 4'hF → ingredient to FALL, mask cleared, fall_dist 0.
  - ISSUE: bound_addr = (ing_y+6)·640 + ing_x+16, computed unsigned and truncated to 19 bits; the value is held stable through WAIT.
  - WAIT: RD_LAT cycles, then bound_q is sampled in UPDATE.
  - UPDATE, FALL only, in priority order:
    1. Next Y = ing_y+FALL_STEP ≥ END_Y → Y = END_Y, PLATE, score_evt pulses.
    2. Else, if any other ingredient j has the same X, is in REST or PLATE, and j.y ≤ next Y+8 → Y = j.y−8, i → REST. If j was REST, j → FALL with fall_dist 0 (cascade).
    3. Else, if bound_q = 1 and fall_dist ≥ MIN_DROP → REST, Y unchanged, fall_dist 0.
    4. Else, Y = next Y, fall_dist += FALL_STEP (saturating at 255).
  - REST and PLATE ingredients pass through ISSUE/WAIT/UPDATE without change, so sweep length is fixed.
- **Latency:** sweep = N_ING·(3+RD_LAT) cycles after the tick. Outputs update within the sweep and are stable at IDLE.
- **Ordering:** at most one move per ingredient per sweep. A cascade-triggered j first moves on the next sweep, even if j > i.
- **score_evt:** two plates in one sweep give two separate pulses.
- **Overrun:** a frame_tick while busy is dropped and overrun pulses; the current sweep completes normally.
- **falling / plated:** registered decodes of ing_state_t.

Decomposition:
- Shared package burger_pkg holds:
  - ing_state_t enum;
  - SCREEN_W = 640, ING_W = 32, ING_H = 8, SEG_COUNT = 4, CHEF_SZ = 16;
  - BOUND_AW = 19.
- One sub-module, bound_addr_gen: combinational (y+6)·SCREEN_W + x+16 with 19-bit truncation. It is reused by the chef ladder lookups.

Test Plan:
- Reset with defaults → ing_y = {236,188,140,92}, all REST, busy = 0. Assert Reset_n=0 mid-sweep → same values next cycle.
- Ingredient 0 at (32,92), chef_y = 76: chef_x 24, 32, 40, 48 on four ticks → seg mask 1, 3, 7, F. falling[0] rises after the 4th sweep; ing_y0 = 92 on that frame, 94 on the next.
- Floor model returns 1 at every row: a falling ingredient moves 92→94→96→98→100 (fall_dist = 8), then stops at 100 in REST. It does not stop before MIN_DROP.
- Floor model all 0, two ingredients: ingredient 0 at (32,92) falling, ingredient 1 resting at (32,140) → ingredient 0 lands at Y 132 in REST, ingredient 1 falling = 1 after the same sweep.
- Falling ingredient at Y 358 → Y = 360, plated = 1, exactly one score_evt pulse, no further motion on later ticks.
- frame_tick on the 2nd cycle of a sweep → overrun pulses once, sweep length unchanged, no extra sweep follows. With RD_LAT = 2, busy stays high for N_ING·5 cycles.
